data_memory_ws: RTL and testbench
=================================

Name: data_memory_ws

Overview:
- Parametrised data memory for the MEM stage of the pipelined MIPS core.
- Adds over the current data memory:
  - byte/halfword/word access with little-endian lane selection;
  - signed/unsigned load extension;
  - alignment and command error detection;
  - configurable wait states, with a stall output that freezes the pipeline until the access completes.
- Sits between the EX/MEM and MEM/WB registers, driven by the MEM-stage control signals.

Parameters:
- ADDR_WIDTH, 9: byte-address width; depth = 2**(ADDR_WIDTH-2) 32-bit words.
- WAIT_STATES, 2: extra busy cycles per access, legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  1  MEM stage presents an access this cycle.
- memRead  in  1  load command.
- memWrite  in  1  store command.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- signedLoad  in  1  sign-extend byte/half loads.
- address  in  ADDR_WIDTH  byte address.
- writeData  in  32  store data, right-aligned.
- readData  out  32  load result, registered.
- stall  out  1  hold the pipeline.
- done  out  1  one-cycle completion pulse.
- err  out  1  access rejected; valid only with done.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; readData=0, done=0, err=0, cnt=0.
  - Memory array not reset.
  - Reset mid-operation aborts the access; a store not yet committed never writes.
- States: IDLE, BUSY, RESP.
- IDLE:
  - stall = req (combinational).
  - On req with an error condition: latch err=1, go RESP, no memory access.
  - Otherwise: latch address/writeData/size/signedLoad/command, cnt<=WAIT_STATES, go BUSY.
- BUSY:
  - stall=1; inputs ignored (req may drop).
  - cnt!=0: decrement cnt.
  - cnt==0: commit the store (byte-enable merge), or capture the extracted and extended load into readData; go RESP.
- RESP:
  - done=1, stall=0, err as latched; go IDLE.
  - The pipeline advances this cycle; a req sampled in the following IDLE cycle is a new access.
- Latency:
  - Normal access: req in cycle 0, done in cycle WAIT_STATES+2; stall high in cycles 0..WAIT_STATES+1.
  - Error access: done/err in cycle 1; stall high in cycle 0 only.
- Error conditions (memory and readData unchanged):
  - size==11;
  - size==01 with address[0]=1;
  - size==10 with address[1:0]!=0;
  - memRead==memWrite (both set or neither set).
- Lanes:
  - Byte lane = address[1:0], lane 0 = bits 7:0.
  - Store byte/half writes only the addressed lanes, taking the low bits of writeData.
  - Load: selected lanes shifted to bit 0, then zero-extended, or sign-extended when signedLoad=1. Word loads ignore signedLoad.
- Word index = address[ADDR_WIDTH-1:2]; no wrap beyond the array.
- readData holds its last load value through stores and errors. Stores and errors do not modify readData.
- done and err are never high outside RESP.

Decomposition:
- Package data_mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum (IDLE/BUSY/RESP);
  - WAIT_STATES range check constant.
- Sub-module mem_lane_align (combinational) contains:
  - store byte-enable generation and data replication;
  - load lane extraction and extension;
  - alignment error decode.
- The FSM, counter and array stay in data_memory_ws.

Test Plan:
- WAIT_STATES=2: sw 0xDEADBEEF @0x10, then lw @0x10 -> each access has stall cycles 0-3 and done in cycle 4; readData=0xDEADBEEF, err=0.
- sb writeData=0x00000080 @0x11, then:
  - lb @0x11 -> 0xFFFFFF80;
  - lbu @0x11 -> 0x00000080;
  - lw @0x10 -> 0xDEAD80EF.
- sh 0x1234 @0x12, then:
  - lw @0x10 -> 0x123480EF;
  - lhu @0x12 -> 0x00001234;
  - lh @0x10 -> 0xFFFF80EF.
- Errors:
  - lw @0x13 -> stall cycle 0 only, done=err=1 in cycle 1, readData unchanged;
  - sh @0x11, memRead=memWrite=1, or size=11 -> same response; lw @0x10 afterwards shows memory unchanged.
- Reset: rst_n low in BUSY (cnt=1) of sw 0x0 @0x10 -> outputs 0, state IDLE; subsequent lw @0x10 returns the prior value.
- WAIT_STATES=0: back-to-back sw/lw, req held continuously -> done in cycle 2 of each access; one IDLE cycle between accesses; correct data returned.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes, FSM states,
// and the legal wait-state range.
// Ports: none (package only).
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The busy counter is 4 bits wide, so more wait states cannot be represented.
  localparam int WS_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  function automatic bit ws_in_range(input int ws);
    return (ws >= 0) && (ws <= WS_MAX);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering for the data memory (combinational).
// Ports: i_size/i_lane/i_signed describe the access; i_wdata is right-aligned store data,
// i_rword is the addressed memory word; outputs are byte enables, replicated store data,
// the extracted/extended load value, and the alignment/reserved-size error.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [31:0] w_shift;

  // Addressed lane moved down to bit 0 before extension.
  assign w_shift = i_rword >> {i_lane, 3'b000};

  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = i_wdata;
    o_rdata    = 32'h0;
    o_misalign = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_lane;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_signed & w_shift[7]}}, w_shift[7:0]};
      end
      SZ_HALF: begin
        o_be       = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = {{16{i_signed & w_shift[15]}}, w_shift[15:0]};
        o_misalign = i_lane[0];
      end
      SZ_WORD: begin
        o_be       = 4'b1111;
        o_rdata    = i_rword;
        o_misalign = |i_lane;
      end
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_ws.sv
// MEM-stage data memory with byte/half/word access and WAIT_STATES busy cycles per access.
// Ports: req + memRead/memWrite/size/signedLoad/address/writeData start an access;
// stall holds the pipeline, done pulses on completion with err, readData holds the last load.
module data_memory_ws
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [1:0]            size,
  input  logic                  signedLoad,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writeData,
  output logic [31:0]           readData,
  output logic                  stall,
  output logic                  done,
  output logic                  err
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  if (!ws_in_range(WAIT_STATES)) begin : g_ws_range
    $error("data_memory_ws: WAIT_STATES must be within 0..15");
  end

  state_t                r_state, w_next;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic                  r_is_store;
  logic                  r_err;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_start, w_reject, w_commit;
  logic [1:0]            w_al_size, w_al_lane;
  logic [3:0]            w_be;
  logic [31:0]           w_wrep, w_load, w_mask, w_rword;
  logic                  w_misalign;
  logic [ADDR_WIDTH-3:0] w_idx;

  // In IDLE the aligner decodes the live request for error detection; afterwards it
  // works on the latched access so the inputs are free to change while busy.
  assign w_al_size = (r_state == IDLE) ? size : r_size;
  assign w_al_lane = (r_state == IDLE) ? address[1:0] : r_addr[1:0];
  assign w_idx     = r_addr[ADDR_WIDTH-1:2];
  assign w_rword   = r_mem[w_idx];

  mem_lane_align u_align (
    .i_size     (w_al_size),
    .i_lane     (w_al_lane),
    .i_signed   (r_signed),
    .i_wdata    (r_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_wrep),
    .o_rdata    (w_load),
    .o_misalign (w_misalign)
  );

  assign w_mask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    stall    = 1'b0;
    w_start  = 1'b0;
    w_reject = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      IDLE: begin
        stall = req;
        if (req) begin
          if (w_misalign || (memRead == memWrite)) begin
            w_reject = 1'b1;
            w_next   = RESP;
          end else begin
            w_start = 1'b1;
            w_next  = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (r_cnt == 4'd0) begin
          w_commit = 1'b1;
          w_next   = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign done = (r_state == RESP);
  assign err  = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_size     <= SZ_BYTE;
      r_signed   <= 1'b0;
      r_is_store <= 1'b0;
      r_err      <= 1'b0;
      readData   <= 32'h0;
    end else begin
      if (w_start) begin
        r_cnt      <= 4'(WAIT_STATES);
        r_addr     <= address;
        r_wdata    <= writeData;
        r_size     <= size;
        r_signed   <= signedLoad;
        r_is_store <= memWrite;
      end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // err is only visible for the single RESP cycle of a rejected access.
      if (w_reject)              r_err <= 1'b1;
      else if (r_state == RESP)  r_err <= 1'b0;
      if (w_commit && !r_is_store) readData <= w_load;
    end
  end

  // Array is not reset; a reset drops the FSM out of BUSY so a pending store never commits.
  always_ff @(posedge clk) begin
    if (w_commit && r_is_store) r_mem[w_idx] <= (w_rword & ~w_mask) | (w_wrep & w_mask);
  end

endmodule

// File: tb/tb_data_memory_ws.sv
module tb_data_memory_ws;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        sel0 = 1'b0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic        signedLoad = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [8:0]  address = 9'h0;
  logic [31:0] writeData = 32'h0;

  logic        req2, req0;
  logic [31:0] rd2, rd0, rdd;
  logic        st2, st0, dn2, dn0, er2, er0, stl, dn, er;

  assign req2 = req & ~sel0;
  assign req0 = req & sel0;
  assign rdd  = sel0 ? rd0 : rd2;
  assign stl  = sel0 ? st0 : st2;
  assign dn   = sel0 ? dn0 : dn2;
  assign er   = sel0 ? er0 : er2;

  data_memory_ws #(.ADDR_WIDTH(9), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .memRead(memRead), .memWrite(memWrite),
    .size(size), .signedLoad(signedLoad), .address(address), .writeData(writeData),
    .readData(rd2), .stall(st2), .done(dn2), .err(er2)
  );

  data_memory_ws #(.ADDR_WIDTH(9), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .memRead(memRead), .memWrite(memWrite),
    .size(size), .signedLoad(signedLoad), .address(address), .writeData(writeData),
    .readData(rd0), .stall(st0), .done(dn0), .err(er0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Reference model: plain byte-addressed memory and the last loaded value (WS=2 instance).
  logic [7:0]  bmem [0:511];
  logic [31:0] exp_rd2 = 32'h0;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [1:0]  sz;
    bit          sgn;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [31:0] exp;
  } op_t;

  function automatic bit model_err(bit rd, bit wr, logic [1:0] sz, logic [8:0] a);
    return (rd == wr) || (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic int nbytes(logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  task automatic model_store(logic [1:0] sz, logic [8:0] a, logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) bmem[int'(a) + i] = wd[8*i +: 8];
  endtask

  function automatic logic [31:0] model_load(logic [1:0] sz, bit sgn, logic [8:0] a);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = nbytes(sz);
    for (int i = 0; i < n; i++) v[8*i +: 8] = bmem[int'(a) + i];
    if (sgn && n < 4 && v[8*n-1]) for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
    return v;
  endfunction

  // Drives one access and reports what was observed, cycle 0 being the first req cycle.
  task automatic access(input bit use0, input bit rd, input bit wr, input logic [1:0] sz,
                        input bit sgn, input logic [8:0] a, input logic [31:0] wd, input bit hold,
                        output logic [31:0] smask, output int dcyc, output int dabs,
                        output logic e, output logic [31:0] r, output bit glitch);
    smask = 32'h0; dcyc = -1; dabs = -1; e = 1'b0; r = 32'h0; glitch = 1'b0;
    @(negedge clk);
    sel0 = use0; memRead = rd; memWrite = wr; size = sz; signedLoad = sgn;
    address = a; writeData = wd; req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (stl) smask[c] = 1'b1;
      if (er && !dn) glitch = 1'b1;
      if (dn) begin
        dcyc = c; dabs = cyc; e = er; r = rdd;
        break;
      end
    end
    if (!hold) req = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    total++; if (rd2 !== 32'h0) begin bad++; $display("FAIL reset_rd got=%h exp=00000000", rd2); end
    total++; if ({st2, dn2, er2} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b exp=000", {st2, dn2, er2}); end
    total++; if ({st0, dn0, er0, rd0} !== 35'h0) begin bad++; $display("FAIL reset_ws0 got=%h exp=0", {st0, dn0, er0, rd0}); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    op_t ops [10];
    logic [31:0] sm, r;
    int dc, da;
    logic e;
    bit g;
    ops = '{
      '{1'b0, 1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 32'h00000000},
      '{1'b1, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        32'hDEADBEEF},
      '{1'b0, 1'b1, 2'b00, 1'b0, 9'h011, 32'h00000080, 32'hDEADBEEF},
      '{1'b1, 1'b0, 2'b00, 1'b1, 9'h011, 32'h0,        32'hFFFFFF80},
      '{1'b1, 1'b0, 2'b00, 1'b0, 9'h011, 32'h0,        32'h00000080},
      '{1'b1, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        32'hDEAD80EF},
      '{1'b0, 1'b1, 2'b01, 1'b0, 9'h012, 32'h00001234, 32'hDEAD80EF},
      '{1'b1, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        32'h123480EF},
      '{1'b1, 1'b0, 2'b01, 1'b0, 9'h012, 32'h0,        32'h00001234},
      '{1'b1, 1'b0, 2'b01, 1'b1, 9'h010, 32'h0,        32'hFFFF80EF}
    };
    foreach (ops[i]) begin
      access(1'b0, ops[i].rd, ops[i].wr, ops[i].sz, ops[i].sgn, ops[i].a, ops[i].wd, 1'b0, sm, dc, da, e, r, g);
      if (ops[i].wr) model_store(ops[i].sz, ops[i].a, ops[i].wd);
      exp_rd2 = ops[i].exp;
      total++; if (r !== ops[i].exp) begin bad++; $display("FAIL dir%0d_data got=%h exp=%h", i, r, ops[i].exp); end
      total++; if (dc !== 4) begin bad++; $display("FAIL dir%0d_done_cycle got=%0d exp=4", i, dc); end
      total++; if (sm !== 32'hF) begin bad++; $display("FAIL dir%0d_stall got=%h exp=0000000f", i, sm); end
      total++; if ((e !== 1'b0) || g) begin bad++; $display("FAIL dir%0d_err got=%b glitch=%b exp=0", i, e, g); end
    end
  endtask

  task automatic test_errors;
    op_t ops [5];
    logic [31:0] sm, r;
    int dc, da;
    logic e;
    bit g;
    ops = '{
      '{1'b1, 1'b0, 2'b10, 1'b0, 9'h013, 32'h0,        32'h0},
      '{1'b0, 1'b1, 2'b01, 1'b0, 9'h011, 32'h0000FFFF, 32'h0},
      '{1'b1, 1'b1, 2'b10, 1'b0, 9'h010, 32'h55555555, 32'h0},
      '{1'b0, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0,        32'h0},
      '{1'b0, 1'b1, 2'b11, 1'b0, 9'h010, 32'hAAAAAAAA, 32'h0}
    };
    foreach (ops[i]) begin
      access(1'b0, ops[i].rd, ops[i].wr, ops[i].sz, ops[i].sgn, ops[i].a, ops[i].wd, 1'b0, sm, dc, da, e, r, g);
      total++; if (dc !== 1) begin bad++; $display("FAIL err%0d_done_cycle got=%0d exp=1", i, dc); end
      total++; if (sm !== 32'h1) begin bad++; $display("FAIL err%0d_stall got=%h exp=00000001", i, sm); end
      total++; if ((e !== 1'b1) || g) begin bad++; $display("FAIL err%0d_err got=%b glitch=%b exp=1", i, e, g); end
      total++; if (r !== exp_rd2) begin bad++; $display("FAIL err%0d_hold got=%h exp=%h", i, r, exp_rd2); end
    end
    access(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 1'b0, sm, dc, da, e, r, g);
    exp_rd2 = model_load(2'b10, 1'b0, 9'h010);
    total++; if (r !== 32'h123480EF) begin bad++; $display("FAIL err_mem_unchanged got=%h exp=123480ef", r); end
  endtask

  task automatic test_mid_reset;
    logic [31:0] sm, r;
    int dc, da;
    logic e;
    bit g;
    @(negedge clk);
    sel0 = 1'b0; memRead = 1'b0; memWrite = 1'b1; size = 2'b10; signedLoad = 1'b0;
    address = 9'h010; writeData = 32'h0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({st2, dn2, er2} !== 3'b000) begin bad++; $display("FAIL midrst_ctl got=%b exp=000", {st2, dn2, er2}); end
    total++; if (rd2 !== 32'h0) begin bad++; $display("FAIL midrst_rd got=%h exp=00000000", rd2); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd2 = 32'h0;
    access(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 1'b0, sm, dc, da, e, r, g);
    exp_rd2 = model_load(2'b10, 1'b0, 9'h010);
    total++; if (r !== 32'h123480EF) begin bad++; $display("FAIL midrst_no_commit got=%h exp=123480ef", r); end
    total++; if (dc !== 4) begin bad++; $display("FAIL midrst_done_cycle got=%0d exp=4", dc); end
  endtask

  task automatic test_random;
    logic [31:0] sm, r, wd;
    int dc, da, k;
    logic e;
    bit g, rd, wr, sgn, xerr;
    logic [1:0] sz;
    logic [8:0] a;
    for (int n = 0; n < 136; n++) begin
      if (n < 16) begin
        rd = 1'b0; wr = 1'b1; sz = 2'b10; sgn = 1'b0; a = 9'(4 * n);
      end else begin
        k = $urandom_range(0, 9);
        rd = (k == 1) || (k >= 6);
        wr = (k >= 1) && (k <= 5);
        sz = 2'($urandom_range(0, 3));
        sgn = 1'($urandom_range(0, 1));
        a = 9'($urandom_range(0, 63));
      end
      wd = $urandom;
      xerr = model_err(rd, wr, sz, a);
      access(1'b0, rd, wr, sz, sgn, a, wd, 1'b0, sm, dc, da, e, r, g);
      if (!xerr) begin
        if (wr) model_store(sz, a, wd);
        else    exp_rd2 = model_load(sz, sgn, a);
      end
      total++; if (r !== exp_rd2) begin bad++; $display("FAIL rnd%0d_data got=%h exp=%h", n, r, exp_rd2); end
      total++; if ((e !== xerr) || g) begin bad++; $display("FAIL rnd%0d_err got=%b glitch=%b exp=%b", n, e, g, xerr); end
      total++; if (dc !== (xerr ? 1 : 4)) begin bad++; $display("FAIL rnd%0d_done_cycle got=%0d exp=%0d", n, dc, xerr ? 1 : 4); end
      total++; if (sm !== (xerr ? 32'h1 : 32'hF)) begin bad++; $display("FAIL rnd%0d_stall got=%h", n, sm); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] sm, r, wd, exp_rd0;
    int dc, da, last;
    logic e;
    bit g;
    logic [8:0] a;
    exp_rd0 = 32'h0;
    last = -1;
    for (int n = 0; n < 12; n++) begin
      if (n % 2 == 0) begin
        a = 9'(4 * $urandom_range(0, 127));
        wd = $urandom;
      end
      access(1'b1, n % 2 == 1, n % 2 == 0, 2'b10, 1'b0, a, wd, n != 11, sm, dc, da, e, r, g);
      if (n % 2 == 1) exp_rd0 = wd;
      total++; if (r !== exp_rd0) begin bad++; $display("FAIL b2b%0d_data got=%h exp=%h", n, r, exp_rd0); end
      total++; if (dc !== 2) begin bad++; $display("FAIL b2b%0d_done_cycle got=%0d exp=2", n, dc); end
      total++; if ((sm !== 32'h3) || (e !== 1'b0) || g) begin bad++; $display("FAIL b2b%0d_stall got=%h err=%b exp=00000003", n, sm, e); end
      if (last >= 0) begin
        total++; if (da - last !== 3) begin bad++; $display("FAIL b2b%0d_gap got=%0d exp=3", n, da - last); end
      end
      last = da;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
